johnson_phase_decoder: RTL and testbench

Registered decode-and-check stage placed directly downstream of the 4-bit Johnson counter. It samples the counter's 4-bit output and converts it into a binary phase index and a one-hot phase strobe. It also checks that each sample is a legal Johnson code and the legal successor of the previous sample, and tracks lock state and full-cycle wraps. Consumers use the phase strobes to sequence eight-phase control and use the lock/error flags to gate that sequencing.

---
 rtl/johnson_phase_decoder.sv | 178 +++++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Registered decoder/checker for a 4-bit Johnson counter. It turns each accepted
// sample into a phase index plus a one-hot strobe. It also flags illegal codes and
// out-of-sequence samples, tracks lock, and counts full-cycle wraps while locked.
module johnson_phase_decoder #(
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        count_in,
    input  logic              err_clr,
    output logic              valid,
    output logic [2:0]        phase,
    output logic [7:0]        phase_oh,
    output logic              locked,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              illegal,
    output logic              skip,
    output logic              err_sticky
);

    localparam int unsigned CntW = $clog2(LOCK_N + 1);
    localparam logic [CntW-1:0] LockTarget = CntW'(LOCK_N);

    typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

    state_e            state_q, state_d;
    logic [2:0]        ref_q, ref_d;
    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CntW-1:0]   lock_cnt_inc;
    logic [2:0]        ref_succ;

    logic              code_legal;
    logic [2:0]        code_idx;
    logic              is_hold, is_succ;
    logic              ev_illegal, ev_skip, ev_wrap;

    logic              valid_q, valid_d;
    logic [7:0]        phase_oh_q, phase_oh_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              illegal_q, illegal_d;
    logic              skip_q, skip_d;
    logic              err_sticky_q, err_sticky_d;

    // Map the eight legal Johnson codes to their phase index.
    always_comb begin
        code_legal = 1'b1;
        code_idx   = 3'd0;
        case (count_in)
            4'b0000: code_idx = 3'd0;
            4'b1000: code_idx = 3'd1;
            4'b1100: code_idx = 3'd2;
            4'b1110: code_idx = 3'd3;
            4'b1111: code_idx = 3'd4;
            4'b0111: code_idx = 3'd5;
            4'b0011: code_idx = 3'd6;
            4'b0001: code_idx = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // Compare the decoded index against the reference; the 3-bit add wraps 7 to 0.
    always_comb begin
        ref_succ     = ref_q + 3'd1;
        lock_cnt_inc = lock_cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        is_hold      = code_legal && (code_idx == ref_q);
        is_succ      = code_legal && (code_idx == ref_succ);
    end

    // FSM state, reference index and lock counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StUnlocked;
            ref_q      <= 3'd0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state logic and per-sample event detection.
    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        lock_cnt_d = lock_cnt_q;
        ev_illegal = 1'b0;
        ev_skip    = 1'b0;
        ev_wrap    = 1'b0;
        if (en) begin
            if (!code_legal) begin
                ev_illegal = 1'b1;
                state_d    = StUnlocked;
            end else begin
                case (state_q)
                    StUnlocked: begin
                        state_d    = StLocking;
                        ref_d      = code_idx;
                        lock_cnt_d = '0;
                    end
                    StLocking: begin
                        if (is_succ) begin
                            ref_d      = code_idx;
                            lock_cnt_d = lock_cnt_inc;
                            if (lock_cnt_inc == LockTarget) begin
                                state_d = StLocked;
                            end
                        end else if (!is_hold) begin
                            ev_skip    = 1'b1;
                            ref_d      = code_idx;
                            lock_cnt_d = '0;
                        end
                    end
                    StLocked: begin
                        if (is_succ) begin
                            ref_d   = code_idx;
                            ev_wrap = (ref_q == 3'd7);
                        end else if (!is_hold) begin
                            ev_skip    = 1'b1;
                            state_d    = StLocking;
                            ref_d      = code_idx;
                            lock_cnt_d = '0;
                        end
                    end
                    default: state_d = StUnlocked;
                endcase
            end
        end
    end

    // Next values of the registered outputs; a new error takes priority over err_clr.
    always_comb begin
        valid_d      = en;
        phase_oh_d   = en ? (8'd1 << ref_d) : 8'd0;
        wrap_d       = ev_wrap;
        wrap_cnt_d   = wrap_cnt_q + WRAP_W'(ev_wrap);
        illegal_d    = ev_illegal;
        skip_d       = ev_skip;
        err_sticky_d = (err_sticky_q & ~err_clr) | ev_illegal | ev_skip;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            phase_oh_q   <= 8'd0;
            wrap_q       <= 1'b0;
            wrap_cnt_q   <= '0;
            illegal_q    <= 1'b0;
            skip_q       <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            phase_oh_q   <= phase_oh_d;
            wrap_q       <= wrap_d;
            wrap_cnt_q   <= wrap_cnt_d;
            illegal_q    <= illegal_d;
            skip_q       <= skip_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Phase always equals the reference index, and locked is decoded from the state flop.
    assign valid      = valid_q;
    assign phase      = ref_q;
    assign phase_oh   = phase_oh_q;
    assign locked     = (state_q == StLocked);
    assign wrap       = wrap_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign illegal    = illegal_q;
    assign skip       = skip_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder. A table of hand-derived vectors is driven on
// negedges; expectations go into a scoreboard queue, and a monitor pops and
// compares them 1 ns after each posedge. Hand-written sequences cover reset.
module tb_johnson_phase_decoder;

    typedef struct packed {
        logic [7:0] id;
        logic       en;
        logic [3:0] code;
        logic       clr;
        logic       valid;
        logic [2:0] phase;
        logic       locked;
        logic       wrap;
        logic [7:0] wcnt;
        logic       illegal;
        logic       skip;
        logic       sticky;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] count_in;
    logic       err_clr;
    logic       valid;
    logic [2:0] phase;
    logic [7:0] phase_oh;
    logic       locked;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic       illegal;
    logic       skip;
    logic       err_sticky;

    int   checks = 0;
    int   passes = 0;
    vec_t vecs[$];
    vec_t sb[$];

    johnson_phase_decoder #(
        .LOCK_N (3),
        .WRAP_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count_in   (count_in),
        .err_clr    (err_clr),
        .valid      (valid),
        .phase      (phase),
        .phase_oh   (phase_oh),
        .locked     (locked),
        .wrap       (wrap),
        .wrap_cnt   (wrap_cnt),
        .illegal    (illegal),
        .skip       (skip),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int e, input logic [3:0] c, input int clr, input int v,
                       input int ph, input int lk, input int wr, input int wc,
                       input int il, input int sk, input int st);
        vec_t x;
        x.id      = 8'(vecs.size());
        x.en      = e[0];
        x.code    = c;
        x.clr     = clr[0];
        x.valid   = v[0];
        x.phase   = 3'(ph);
        x.locked  = lk[0];
        x.wrap    = wr[0];
        x.wcnt    = 8'(wc);
        x.illegal = il[0];
        x.skip    = sk[0];
        x.sticky  = st[0];
        vecs.push_back(x);
    endtask

    task automatic drive(input vec_t x);
        @(negedge clk);
        en       = x.en;
        count_in = x.code;
        err_clr  = x.clr;
        sb.push_back(x);
    endtask

    task automatic check_zero(input int tag);
        checks++;
        if (valid !== 1'b0 || phase !== 3'd0 || phase_oh !== 8'd0 || locked !== 1'b0 ||
            wrap !== 1'b0 || wrap_cnt !== 8'd0 || illegal !== 1'b0 || skip !== 1'b0 ||
            err_sticky !== 1'b0) begin
            $display("FAIL reset%0d: got v=%b ph=%0d oh=%h lk=%b wr=%b wc=%0d il=%b sk=%b st=%b, want all 0",
                     tag, valid, phase, phase_oh, locked, wrap, wrap_cnt, illegal, skip,
                     err_sticky);
        end else begin
            passes++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (sb.size() != 0) @(posedge clk);
        end
        #2;
        checks++;
        if (sb.size() != 0) $display("FAIL drain: got %0d pending, want 0", sb.size());
        else passes++;
    endtask

    // Scoreboard monitor: compare the oldest expectation 1 ns after each rising edge.
    always @(posedge clk) begin
        vec_t       e;
        logic [7:0] want_oh;
        #1;
        if (sb.size() != 0) begin
            e       = sb.pop_front();
            want_oh = e.valid ? (8'd1 << e.phase) : 8'd0;
            checks++;
            if (valid !== e.valid || phase !== e.phase || phase_oh !== want_oh ||
                locked !== e.locked || wrap !== e.wrap || wrap_cnt !== e.wcnt ||
                illegal !== e.illegal || skip !== e.skip || err_sticky !== e.sticky) begin
                $display("FAIL step%0d: got v=%b ph=%0d oh=%h lk=%b wr=%b wc=%0d il=%b sk=%b st=%b, want v=%b ph=%0d oh=%h lk=%b wr=%b wc=%0d il=%b sk=%b st=%b",
                         e.id, valid, phase, phase_oh, locked, wrap, wrap_cnt, illegal, skip,
                         err_sticky, e.valid, e.phase, want_oh, e.locked, e.wrap, e.wcnt,
                         e.illegal, e.skip, e.sticky);
            end else begin
                passes++;
            end
        end
    end

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        count_in = 4'b0000;
        err_clr  = 1'b0;

        //  en  code    clr v  ph lk wr wc il sk st
        add(1, 4'b0101, 0, 1, 0, 0, 0, 0, 1, 0, 1); // illegal while unlocked
        add(0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0); // clear sticky
        add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0); // clean walk
        add(1, 4'b1000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1110, 0, 1, 3, 1, 0, 0, 0, 0, 0); // third successor locks
        add(1, 4'b1111, 0, 1, 4, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0111, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0011, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0001, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 0, 1, 0, 1, 1, 1, 0, 0, 0); // locked wrap
        add(1, 4'b1010, 0, 1, 0, 0, 0, 1, 1, 0, 1); // illegal while locked
        add(1, 4'b0011, 0, 1, 6, 0, 0, 1, 0, 0, 1);
        add(1, 4'b0001, 0, 1, 7, 0, 0, 1, 0, 0, 1);
        add(1, 4'b0000, 0, 1, 0, 0, 0, 1, 0, 0, 1); // 7->0 while locking: no wrap
        add(1, 4'b1000, 0, 1, 1, 1, 0, 1, 0, 0, 1);
        add(1, 4'b1110, 0, 1, 3, 0, 0, 1, 0, 1, 1); // skip drops lock
        add(1, 4'b1111, 0, 1, 4, 0, 0, 1, 0, 0, 1);
        add(1, 4'b0111, 0, 1, 5, 0, 0, 1, 0, 0, 1);
        add(1, 4'b0011, 0, 1, 6, 1, 0, 1, 0, 0, 1);
        add(0, 4'b0000, 1, 0, 6, 1, 0, 1, 0, 0, 0); // clear alone
        add(1, 4'b1000, 1, 1, 1, 0, 0, 1, 0, 1, 1); // skip beats err_clr
        add(0, 4'b0000, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 1, 0, 0, 0);
        add(1, 4'b1110, 0, 1, 3, 0, 0, 1, 0, 0, 0);
        add(1, 4'b1111, 0, 1, 4, 1, 0, 1, 0, 0, 0);
        add(0, 4'b1010, 0, 0, 4, 1, 0, 1, 0, 0, 0); // enable gap ignores input
        add(0, 4'b0000, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        add(0, 4'b0101, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        add(1, 4'b1111, 0, 1, 4, 1, 0, 1, 0, 0, 0); // hold after gap
        add(1, 4'b0111, 0, 1, 5, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0011, 0, 1, 6, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0001, 0, 1, 7, 1, 0, 1, 0, 0, 0);
        add(1, 4'b0000, 0, 1, 0, 1, 1, 2, 0, 0, 0); // second wrap
        add(1, 4'b0000, 0, 1, 0, 1, 0, 2, 0, 0, 0); // hold on 0: no wrap

        // Reset held: outputs stay zero while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en       = 1'($urandom);
            count_in = 4'($urandom);
            err_clr  = 1'($urandom);
            @(posedge clk);
            #1;
            check_zero(i);
        end
        @(negedge clk);
        rst      = 1'b1;
        en       = 1'b0;
        err_clr  = 1'b0;
        count_in = 4'b0000;

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        @(negedge clk);
        en      = 1'b0;
        err_clr = 1'b0;
        drain();

        // Asynchronous reset mid-run, away from any clock edge.
        @(negedge clk);
        en       = 1'b1;
        count_in = 4'b0001;
        #2;
        rst = 1'b0;
        #1;
        check_zero(10);
        @(posedge clk);
        #1;
        check_zero(11);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;

        // After reset, lock must be rebuilt from scratch.
        vecs.delete();
        add(1, 4'b1000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1100, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1110, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        add(1, 4'b1111, 0, 1, 4, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        @(negedge clk);
        en = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
